vend_ctrl: RTL

VEND_CTRL -- requirements
Module: vend_ctrl

---
 rtl/vend_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/vend_ctrl.sv
// -----------------------------------------------------------------------------
// vend_ctrl -- cola vending machine controller
//
// Collects 0.5 and 1.0 coins as credit counted in half units. When the
// credit reaches PRICE it requests a dispense and waits for an acknowledge
// from the dispenser. Any remainder is then paid back one half unit per
// cycle. A cancel before the price is reached refunds the whole credit. If
// the dispenser never acknowledges, the price is added back and refunded,
// and a fault pulse is raised.
//
// Parameters
//   PRICE        cola price in half-unit credits (default 5 = 2.5)
//   ACK_TIMEOUT  VEND cycles to wait for pi_cola_ack before refunding (1..255)
//
// Ports
//   clk             single clock, rising edge
//   rst             synchronous, active-high reset
//   pi_money_half   one-cycle pulse, 0.5 coin inserted
//   pi_money_one    one-cycle pulse, 1.0 coin inserted
//   pi_cancel       one-cycle pulse, refund request
//   pi_cola_ack     dispenser released one cola
//   po_cola_req     dispense request level (high throughout VEND)
//   po_change_half  one pulse per 0.5 returned
//   po_coin_reject  pulse, coin inserted while busy was returned
//   po_fault        pulse, dispenser acknowledge timed out
//   po_credit       current credit in half units
//   po_busy         high while vending or returning change
// -----------------------------------------------------------------------------
module vend_ctrl #(
  parameter int PRICE       = 5,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pi_money_half,
  input  logic       pi_money_one,
  input  logic       pi_cancel,
  input  logic       pi_cola_ack,
  output logic       po_cola_req,
  output logic       po_change_half,
  output logic       po_coin_reject,
  output logic       po_fault,
  output logic [2:0] po_credit,
  output logic       po_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_VEND,
    S_CHANGE
  } state_t;

  localparam logic [3:0] PRICE_W  = 4'(PRICE);
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [2:0] credit_q, credit_d;
  logic [7:0] cnt_q, cnt_d;
  logic       reject_q, reject_d;
  logic       fault_q, fault_d;

  logic [3:0] value;
  logic [3:0] sum;

  // A half coin is worth 1, a full coin 2; both together 3. That is exactly
  // the two pulse bits read as a 2-bit number.
  function automatic logic [3:0] coin_value(input logic half, input logic one);
    return {2'b00, one, half};
  endfunction

  // Sum is one bit wider than credit so the price comparison can never wrap.
  assign value = coin_value(pi_money_half, pi_money_one);
  assign sum   = {1'b0, credit_q} + value;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    cnt_d    = cnt_q;
    reject_d = 1'b0;
    fault_d  = 1'b0;

    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (sum >= PRICE_W) begin
          // Reaching the price takes priority over a same-cycle cancel.
          state_d  = S_VEND;
          credit_d = 3'(sum - PRICE_W);
          cnt_d    = 8'd0;
        end else begin
          credit_d = sum[2:0];
          // COLLECT always holds nonzero credit, so a cancel there has
          // something to refund; a cancel in IDLE is simply ignored.
          if (state_q == S_COLLECT && pi_cancel) begin
            state_d = S_CHANGE;
          end else if (sum != 4'd0) begin
            state_d = S_COLLECT;
          end
        end
      end

      S_VEND: begin
        reject_d = (value != 4'd0);
        if (pi_cola_ack) begin
          state_d = (credit_q != 3'd0) ? S_CHANGE : S_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          // No cola came out: give the price back along with any remainder.
          credit_d = 3'({1'b0, credit_q} + PRICE_W);
          fault_d  = 1'b1;
          state_d  = S_CHANGE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_CHANGE: begin
        reject_d = (value != 4'd0);
        // Every path into CHANGE carries nonzero credit; the zero guard only
        // keeps an impossible state from wrapping the register.
        if (credit_q <= 3'd1) begin
          credit_d = 3'd0;
          state_d  = S_IDLE;
        end else begin
          credit_d = credit_q - 3'd1;
        end
      end

      default: begin
        state_d  = S_IDLE;
        credit_d = 3'd0;
        cnt_d    = 8'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      credit_q <= 3'd0;
      cnt_q    <= 8'd0;
      reject_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      cnt_q    <= cnt_d;
      reject_q <= reject_d;
      fault_q  <= fault_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registers only
  // ---------------------------------------------------------------------------
  // Credit decrements on every CHANGE cycle, so being in CHANGE is the
  // change pulse itself.
  assign po_cola_req    = (state_q == S_VEND);
  assign po_change_half = (state_q == S_CHANGE);
  assign po_busy        = (state_q == S_VEND) || (state_q == S_CHANGE);
  assign po_coin_reject = reject_q;
  assign po_fault       = fault_q;
  assign po_credit      = credit_q;

endmodule
